// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares one single-port frame RAM between the scaler
// write stream and the display readout stream. One grant per cycle; read
// data returns one cycle after the read grant. Counts in-range writes to
// mark frame completion and flags out-of-range addresses (sticky).
// Optional build macro: RR_ARB_EN selects round-robin conflict arbitration
// instead of fixed write priority with the MAX_WAIT starvation guard.
module frame_ram_arbiter #(
  parameter int SIZE     = 518400,
  parameter int AW       = $clog2(SIZE),
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_re,
  input  logic [DW-1:0] ram_q,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic          err_addr
);

  // SIZE is compared one bit wider than the address so that SIZE == 2**AW
  // (and addresses at or above SIZE) are handled without truncation.
  localparam logic [AW:0]   SIZE_EXT = (AW+1)'(SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

  logic          wr_oor;
  logic          rd_oor;
  logic          read_wins;
  logic          rd_oor_q;
  logic [AW-1:0] wr_cnt;

  assign wr_oor = ({1'b0, wr_addr} >= SIZE_EXT);
  assign rd_oor = ({1'b0, rd_addr} >= SIZE_EXT);

`ifdef RR_ARB_EN
  typedef enum logic {LAST_RD, LAST_WR} winner_t;
  winner_t last_winner;

  assign read_wins = (last_winner == LAST_WR);

  // Remember who won the most recent conflict so the other side wins next.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_winner <= LAST_RD;
    end else if (wr_req && rd_req) begin
      last_winner <= rd_gnt ? LAST_RD : LAST_WR;
    end
  end
`else
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] WAIT_MAX = SW'(MAX_WAIT);
  logic [SW-1:0] starve_cnt;

  assign read_wins = (starve_cnt == WAIT_MAX);

  // Count consecutive refused read cycles, saturating at MAX_WAIT.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      starve_cnt <= '0;
    end else if (rd_req && !rd_gnt) begin
      if (starve_cnt != WAIT_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  // Grant selection and RAM port mux; out-of-range accesses are granted
  // but their RAM strobes are suppressed.
  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_wdata = '0;
    if (!HRESET) begin
      if (wr_req && !(rd_req && read_wins)) begin
        wr_gnt    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
        ram_we    = !wr_oor;
      end else if (rd_req) begin
        rd_gnt   = 1'b1;
        ram_addr = rd_addr;
        ram_re   = !rd_oor;
      end
    end
  end

  assign frame_done = wr_gnt && !wr_oor && (wr_cnt == LAST_IDX);
  assign rd_data    = rd_oor_q ? '0 : ram_q;

  // Read-valid pipeline, write/frame counters and sticky address error.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_valid  <= 1'b0;
      rd_oor_q  <= 1'b0;
      wr_cnt    <= '0;
      frame_cnt <= '0;
      err_addr  <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      rd_oor_q <= rd_gnt && rd_oor;
      if ((wr_gnt && wr_oor) || (rd_gnt && rd_oor)) begin
        err_addr <= 1'b1;
      end
      if (wr_gnt && !wr_oor) begin
        if (frame_done) begin
          wr_cnt    <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter with SIZE=16 (AW=5 so addresses >= SIZE are
// expressible). A behavioural RAM with 1-cycle read latency sits on the RAM
// port; expected read data is queued at grant time and popped on rd_valid.
module tb_frame_ram_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       wr_req = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_gnt;
  logic       rd_req = 1'b0;
  logic [4:0] rd_addr = '0;
  logic       rd_gnt;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic       ram_re;
  logic [7:0] ram_q = '0;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       err_addr;

  frame_ram_arbiter #(.SIZE(16), .AW(5), .DW(8), .MAX_WAIT(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_q(ram_q),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .err_addr(err_addr)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural single-port RAM, registered read.
  logic [7:0] bram [32];
  initial for (int i = 0; i < 32; i++) bram[i] = '0;
  always @(posedge HCLK) begin
    if (ram_we) bram[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= bram[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [7:0] mem [32];
  logic [7:0] exp_q [$];
  int         m_wcnt = 0;
  int         m_frames = 0;
  logic       m_err = 1'b0;
  int         m_starve = 0;
  logic       m_last_wr = 1'b0;
  int         fd_seen = 0;
  int         fd_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_frames = 0; m_err = 1'b0; m_starve = 0; m_last_wr = 1'b0;
    exp_q.delete();
  endtask

  // Read-data monitor: runs 3 time units after each rising edge.
  initial forever begin
    @(posedge HCLK); #3;
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("rd_data", {24'd0, rd_data}, {24'd0, e});
    end else if (rd_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rd_valid_unexpected: got 1 expected 0");
    end
  end

  // One arbitration cycle: drive after the edge, check at the falling edge.
  task automatic cycle(input logic wq, input logic [4:0] wa, input logic [7:0] wd,
                       input logic rq, input logic [4:0] ra,
                       input logic ew, input logic er, input logic [4:0] eaddr,
                       input string name);
    logic w_in, r_in, efd;
    @(posedge HCLK); #1;
    wr_req = wq; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
    @(negedge HCLK);
    w_in = (wa < 5'd16);
    r_in = (ra < 5'd16);
    efd  = ew && w_in && (m_wcnt == 15);
    chk({name, ".wr_gnt"},     {31'd0, wr_gnt},     {31'd0, ew});
    chk({name, ".rd_gnt"},     {31'd0, rd_gnt},     {31'd0, er});
    chk({name, ".ram_we"},     {31'd0, ram_we},     {31'd0, ew && w_in});
    chk({name, ".ram_re"},     {31'd0, ram_re},     {31'd0, er && r_in});
    chk({name, ".ram_addr"},   {27'd0, ram_addr},   {27'd0, eaddr});
    chk({name, ".frame_done"}, {31'd0, frame_done}, {31'd0, efd});
    chk({name, ".frame_cnt"},  {24'd0, frame_cnt},  m_frames[7:0]);
    chk({name, ".err_addr"},   {31'd0, err_addr},   {31'd0, m_err});
    if (ew) chk({name, ".ram_wdata"}, {24'd0, ram_wdata}, {24'd0, wd});
    if (frame_done) fd_seen++;
    if (ew && w_in) begin
      mem[wa] = wd;
      if (m_wcnt == 15) begin m_wcnt = 0; m_frames = (m_frames + 1) % 256; end
      else m_wcnt++;
    end
    if ((ew && !w_in) || (er && !r_in)) m_err = 1'b1;
    if (er) exp_q.push_back(r_in ? mem[ra] : 8'h00);
    if (rq && !er) m_starve = (m_starve == 4) ? 4 : m_starve + 1;
    else m_starve = 0;
    if (wq && rq) m_last_wr = ew;
  endtask

  // Cycle whose grant expectation comes from the arbitration model.
  task automatic mcycle(input logic wq, input logic [4:0] wa, input logic [7:0] wd,
                        input logic rq, input logic [4:0] ra, input string name,
                        output logic er_out);
    logic rw, ew, er;
`ifdef RR_ARB_EN
    rw = m_last_wr;
`else
    rw = (m_starve == 4);
`endif
    ew = wq && !(rq && rw);
    er = rq && !ew;
    cycle(wq, wa, wd, rq, ra, ew, er, ew ? wa : (er ? ra : 5'd0), name);
    er_out = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, "idle");
  endtask

  task automatic write_run(input int n, input logic [7:0] base);
    logic er;
    for (int i = 0; i < n; i++) begin
      mcycle(1'b1, 5'(i % 16), base + 8'(i), 1'b0, 5'd0, "frame_wr", er);
      if (frame_done && fd_at < 0) fd_at = i;
    end
  endtask

  typedef struct {
    logic       wq; logic [4:0] wa; logic [7:0] wd;
    logic       rq; logic [4:0] ra;
    logic       ew; logic er; logic [4:0] eaddr;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic er;
    int   n_rd, nw, first_rd;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    tbl[0] = '{1'b1, 5'h0A, 8'hA5, 1'b0, 5'h00, 1'b1, 1'b0, 5'h0A};
    tbl[1] = '{1'b0, 5'h00, 8'h00, 1'b0, 5'h00, 1'b0, 1'b0, 5'h00};
    tbl[2] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h0A, 1'b0, 1'b1, 5'h0A};
    tbl[3] = '{1'b1, 5'h03, 8'h3C, 1'b0, 5'h00, 1'b1, 1'b0, 5'h03};
    tbl[4] = '{1'b1, 5'h0F, 8'hFF, 1'b0, 5'h00, 1'b1, 1'b0, 5'h0F};
    tbl[5] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h03, 1'b0, 1'b1, 5'h03};
    tbl[6] = '{1'b0, 5'h00, 8'h00, 1'b1, 5'h0F, 1'b0, 1'b1, 5'h0F};
    tbl[7] = '{1'b1, 5'h00, 8'h11, 1'b0, 5'h00, 1'b1, 1'b0, 5'h00};

    // Reset with both requests high: nothing may be granted or strobed.
    for (int i = 0; i < 2; i++) begin
      @(posedge HCLK); #1;
      HRESET = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_addr = 5'h01; rd_addr = 5'h02;
      @(negedge HCLK);
      chk("rst.wr_gnt", {31'd0, wr_gnt}, 32'd0);
      chk("rst.rd_gnt", {31'd0, rd_gnt}, 32'd0);
      chk("rst.ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst.ram_re", {31'd0, ram_re}, 32'd0);
      if (i == 1) begin
        chk("rst.rd_valid",  {31'd0, rd_valid}, 32'd0);
        chk("rst.frame_cnt", {24'd0, frame_cnt}, 32'd0);
        chk("rst.err_addr",  {31'd0, err_addr}, 32'd0);
      end
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();

    // Lone requesters from the vector table.
    foreach (tbl[i])
      cycle(tbl[i].wq, tbl[i].wa, tbl[i].wd, tbl[i].rq, tbl[i].ra,
            tbl[i].ew, tbl[i].er, tbl[i].eaddr, $sformatf("vec%0d", i));
    idle(1);

    // Sustained conflict: 4W,1R in the default build, alternation with RR.
    n_rd = 0; nw = 0;
    for (int i = 0; i < 10; i++) begin
      mcycle(1'b1, 5'h01, 8'h40 + 8'(nw), 1'b1, 5'h0A, "conflict", er);
      if (er) n_rd++; else nw++;
    end
`ifdef RR_ARB_EN
    chk("conflict.reads", n_rd, 32'd5);
`else
    chk("conflict.reads", n_rd, 32'd2);
`endif

    // Dropping rd_req clears the starvation count.
    for (int i = 0; i < 2; i++) begin
      mcycle(1'b1, 5'h02, 8'h60 + 8'(nw), 1'b1, 5'h0A, "starve_a", er);
      if (!er) nw++;
    end
    mcycle(1'b1, 5'h02, 8'h60 + 8'(nw), 1'b0, 5'h0A, "starve_gap", er);
    nw++;
    first_rd = -1;
    for (int i = 0; i < 5; i++) begin
      mcycle(1'b1, 5'h02, 8'h60 + 8'(nw), 1'b1, 5'h0A, "starve_b", er);
      if (er && first_rd < 0) first_rd = i;
      if (!er) nw++;
    end
`ifndef RR_ARB_EN
    chk("starve.first_read", first_rd, 32'd4);
`endif
    idle(2);

    // Frame completion from a clean write counter.
    @(posedge HCLK); #1; HRESET = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
    @(posedge HCLK); #1; HRESET = 1'b0;
    fd_seen = 0; fd_at = -1;
    write_run(16, 8'h80);
    idle(1);
    chk("frame.done_pulses", fd_seen, 32'd1);
    chk("frame.done_index", fd_at, 32'd15);
    chk("frame.cnt1", {24'd0, frame_cnt}, 32'd1);
    fd_at = -1;
    write_run(16, 8'hC0);
    idle(1);
    chk("frame.cnt2", {24'd0, frame_cnt}, 32'd2);

    // Out-of-range read and write: granted, no strobe, zero data, sticky error.
    mcycle(1'b0, 5'd0, 8'd0, 1'b1, 5'h0A, "pre_bad_rd", er);
    mcycle(1'b0, 5'd0, 8'd0, 1'b1, 5'd16, "bad_rd", er);
    chk("bad_rd.granted", {31'd0, er}, 32'd1);
    idle(3);
    chk("bad.err_sticky", {31'd0, err_addr}, 32'd1);
    mcycle(1'b1, 5'd20, 8'h77, 1'b0, 5'd0, "bad_wr", er);
    idle(2);

    // Reset arriving on the edge after a read grant.
    for (int i = 0; i < 3; i++) mcycle(1'b1, 5'(i), 8'h20 + 8'(i), 1'b0, 5'd0, "pre_rst", er);
    mcycle(1'b0, 5'd0, 8'd0, 1'b1, 5'h03, "rd_before_rst", er);
    HRESET = 1'b1;
    model_reset();
    @(posedge HCLK); #1; rd_req = 1'b0;
    @(negedge HCLK);
    chk("midrst.rd_valid",  {31'd0, rd_valid}, 32'd0);
    chk("midrst.frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("midrst.err_addr",  {31'd0, err_addr}, 32'd0);
    @(posedge HCLK); #1; HRESET = 1'b0;
    fd_seen = 0; fd_at = -1;
    write_run(16, 8'h50);
    idle(1);
    chk("midrst.done_index", fd_at, 32'd15);
    chk("midrst.frame_cnt1", {24'd0, frame_cnt}, 32'd1);
    idle(1);
    chk("drain.queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
